periph_bus_arbiter: RTL and testbench

//  Two-master arbiter and sequencer for the peripheral data bus that feeds the address-decode bridge.
//  M0 = CPU data port; M1 = auxiliary master (debug loader / DMA).

---
 rtl/bus_arb_pkg.sv | 31 +++
 rtl/arb_rr_pick.sv | 27 ++
 rtl/periph_bus_arbiter.sv | 135 +++++++++++++
 tb/tb_periph_bus_arbiter.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/bus_arb_pkg.sv
// Shared types and constants for the peripheral bus arbiter (state encoding, master ids, slow-region defaults).
// Build option: BUS_ARB_FIXED_PRIO_EN selects fixed M0 priority inside arb_rr_pick.
package bus_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WAIT   = 2'd2,
        DONE   = 2'd3
    } state_e;

    localparam logic M0 = 1'b0;
    localparam logic M1 = 1'b1;

    // Default UART window of the peripheral address map.
    localparam logic [31:0] SLOW_BASE_DEF = 32'h0000_7F30;
    localparam logic [31:0] SLOW_END_DEF  = 32'h0000_7F3F;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  byteen;
    } xact_t;

    function automatic logic in_region(input logic [31:0] addr,
                                       input logic [31:0] lo,
                                       input logic [31:0] hi);
        return (addr >= lo) && (addr <= hi);
    endfunction

endpackage

// File: rtl/arb_rr_pick.sv
// Two-way request picker: round-robin on a tie (winner = !last), or fixed M0 priority
// when BUS_ARB_FIXED_PRIO_EN is defined. Purely combinational.
module arb_rr_pick
    import bus_arb_pkg::*;
(
    input  logic [1:0] req_i,
    input  logic       last_i,
    output logic       winner_o
);

`ifdef BUS_ARB_FIXED_PRIO_EN
    logic unused_last;
    assign unused_last = last_i;
    assign winner_o    = req_i[0] ? M0 : M1;
`else
    always_comb begin
        winner_o = M0;
        case (req_i)
            2'b01:   winner_o = M0;
            2'b10:   winner_o = M1;
            2'b11:   winner_o = ~last_i;
            default: winner_o = M0;
        endcase
    end
`endif

endmodule

// File: rtl/periph_bus_arbiter.sv
// Two-master sequencer for the peripheral data bus: one access in flight, one-cycle write strobe,
// wait states for the slow region. Tie policy set by BUS_ARB_FIXED_PRIO_EN (default round-robin).
module periph_bus_arbiter
    import bus_arb_pkg::*;
#(
    parameter logic [31:0] SLOW_BASE = SLOW_BASE_DEF,
    parameter logic [31:0] SLOW_END  = SLOW_END_DEF,
    parameter int unsigned SLOW_WAIT = 2
) (
    input  logic        clk,
    input  logic        sys_rstn,
    input  logic        m0_req,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic [3:0]  m0_byteen,
    output logic        m0_gnt,
    output logic        m0_rvalid,
    input  logic        m1_req,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    input  logic [3:0]  m1_byteen,
    output logic        m1_gnt,
    output logic        m1_rvalid,
    output logic [31:0] rdata,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_raddr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_byteen,
    input  logic [31:0] bus_rdata
);

    localparam logic [3:0] WAIT_CYC = 4'(SLOW_WAIT);

    state_e      state_q;
    xact_t       xact_q;
    logic        win_q;
    logic        last_q;
    logic        slow_q;
    logic [3:0]  cnt_q;
    logic        m0_gnt_q, m1_gnt_q;
    logic        m0_rvalid_q, m1_rvalid_q;
    logic [31:0] bus_addr_q, bus_wdata_q;
    logic [3:0]  bus_byteen_q;

    logic        winner_d;
    xact_t       sel_d;

    arb_rr_pick u_pick (
        .req_i    ({m1_req, m0_req}),
        .last_i   (last_q),
        .winner_o (winner_d)
    );

    assign sel_d = (winner_d == M1) ? '{addr: m1_addr, wdata: m1_wdata, byteen: m1_byteen}
                                    : '{addr: m0_addr, wdata: m0_wdata, byteen: m0_byteen};

    always_ff @(posedge clk) begin
        if (!sys_rstn) begin
            state_q      <= IDLE;
            xact_q       <= '0;
            win_q        <= M0;
            last_q       <= M1;
            slow_q       <= 1'b0;
            cnt_q        <= '0;
            m0_gnt_q     <= 1'b0;
            m1_gnt_q     <= 1'b0;
            m0_rvalid_q  <= 1'b0;
            m1_rvalid_q  <= 1'b0;
            bus_addr_q   <= '0;
            bus_wdata_q  <= '0;
            bus_byteen_q <= '0;
        end else begin
            m0_gnt_q    <= 1'b0;
            m1_gnt_q    <= 1'b0;
            m0_rvalid_q <= 1'b0;
            m1_rvalid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (m0_req || m1_req) begin
                        xact_q       <= sel_d;
                        win_q        <= winner_d;
                        slow_q       <= in_region(sel_d.addr, SLOW_BASE, SLOW_END);
                        bus_addr_q   <= sel_d.addr;
                        bus_wdata_q  <= sel_d.wdata;
                        bus_byteen_q <= sel_d.byteen;
                        m0_gnt_q     <= (winner_d == M0);
                        m1_gnt_q     <= (winner_d == M1);
                        state_q      <= ACCESS;
                    end
                end
                ACCESS: begin
                    // Write strobe lives only in ACCESS: exactly one bridge WE per write.
                    bus_byteen_q <= '0;
                    if (slow_q && (WAIT_CYC != 4'd0)) begin
                        cnt_q   <= WAIT_CYC;
                        state_q <= WAIT;
                    end else begin
                        m0_rvalid_q <= (win_q == M0);
                        m1_rvalid_q <= (win_q == M1);
                        state_q     <= DONE;
                    end
                end
                WAIT: begin
                    if (cnt_q <= 4'd1) begin
                        m0_rvalid_q <= (win_q == M0);
                        m1_rvalid_q <= (win_q == M1);
                        state_q     <= DONE;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                DONE: begin
                    last_q      <= win_q;
                    bus_addr_q  <= '0;
                    bus_wdata_q <= '0;
                    state_q     <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign m0_gnt     = m0_gnt_q;
    assign m1_gnt     = m1_gnt_q;
    assign m0_rvalid  = m0_rvalid_q;
    assign m1_rvalid  = m1_rvalid_q;
    assign bus_addr   = bus_addr_q;
    assign bus_raddr  = bus_addr_q;
    assign bus_wdata  = bus_wdata_q;
    assign bus_byteen = bus_byteen_q;

    // Synchronous DM data only appears in DONE, so it is gated through rather than registered.
    assign rdata = ((state_q == DONE) && (xact_q.byteen == 4'h0)) ? bus_rdata : 32'h0;

endmodule

// File: tb/tb_periph_bus_arbiter.sv
// Directed table-driven bench for periph_bus_arbiter, plus sequences for arbitration order,
// reset during a wait state, and back-to-back write strobe spacing.
module tb_periph_bus_arbiter;

    logic        clk = 1'b0;
    logic        sys_rstn;
    logic        m0_req, m1_req;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic [3:0]  m0_byteen, m1_byteen;
    logic        m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
    logic [31:0] rdata, bus_addr, bus_raddr, bus_wdata, bus_rdata;
    logic [3:0]  bus_byteen;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    periph_bus_arbiter dut (
        .clk        (clk),
        .sys_rstn   (sys_rstn),
        .m0_req     (m0_req),
        .m0_addr    (m0_addr),
        .m0_wdata   (m0_wdata),
        .m0_byteen  (m0_byteen),
        .m0_gnt     (m0_gnt),
        .m0_rvalid  (m0_rvalid),
        .m1_req     (m1_req),
        .m1_addr    (m1_addr),
        .m1_wdata   (m1_wdata),
        .m1_byteen  (m1_byteen),
        .m1_gnt     (m1_gnt),
        .m1_rvalid  (m1_rvalid),
        .rdata      (rdata),
        .bus_addr   (bus_addr),
        .bus_raddr  (bus_raddr),
        .bus_wdata  (bus_wdata),
        .bus_byteen (bus_byteen),
        .bus_rdata  (bus_rdata)
    );

    typedef struct {
        logic        mst;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [31:0] brd;
        int          w;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t vt[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " gnt"},    {30'd0, m1_gnt, m0_gnt}, 32'd0);
        check({tag, " rvalid"}, {30'd0, m1_rvalid, m0_rvalid}, 32'd0);
        check({tag, " rdata"},  rdata, 32'd0);
        check({tag, " addr"},   bus_addr, 32'd0);
        check({tag, " raddr"},  bus_raddr, 32'd0);
        check({tag, " wdata"},  bus_wdata, 32'd0);
        check({tag, " byteen"}, {28'd0, bus_byteen}, 32'd0);
    endtask

    task automatic drive_req(input logic mst, input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        if (mst) begin
            m1_req = 1'b1; m1_addr = a; m1_wdata = d; m1_byteen = be;
        end else begin
            m0_req = 1'b1; m0_addr = a; m0_wdata = d; m0_byteen = be;
        end
    endtask

    task automatic drop_reqs();
        m0_req = 1'b0; m1_req = 1'b0;
    endtask

    task automatic do_reset(input int cycles);
        sys_rstn = 1'b0;
        drop_reqs();
        repeat (cycles) @(negedge clk);
        sys_rstn = 1'b1;
    endtask

    // Entered at a negedge with the DUT in IDLE; returns at the negedge of the following IDLE cycle.
    task automatic run_vec(input int idx, input vec_t v);
        string       tag;
        logic [31:0] exp_bits;
        tag      = $sformatf("vec%0d", idx);
        exp_bits = v.mst ? 32'd2 : 32'd1;
        bus_rdata = v.brd;
        drive_req(v.mst, v.addr, v.wdata, v.be);
        @(posedge clk); @(negedge clk);
        check({tag, " access gnt"},    {30'd0, m1_gnt, m0_gnt}, exp_bits);
        check({tag, " access rvalid"}, {30'd0, m1_rvalid, m0_rvalid}, 32'd0);
        check({tag, " access byteen"}, {28'd0, bus_byteen}, {28'd0, v.be});
        check({tag, " access addr"},   bus_addr, v.addr);
        check({tag, " access raddr"},  bus_raddr, v.addr);
        check({tag, " access wdata"},  bus_wdata, v.wdata);
        drop_reqs();
        for (int k = 0; k < v.w; k++) begin
            @(negedge clk);
            check({tag, " wait byteen"}, {28'd0, bus_byteen}, 32'd0);
            check({tag, " wait gnt"},    {30'd0, m1_gnt, m0_gnt}, 32'd0);
            check({tag, " wait rvalid"}, {30'd0, m1_rvalid, m0_rvalid}, 32'd0);
            check({tag, " wait raddr"},  bus_raddr, v.addr);
        end
        @(negedge clk);
        check({tag, " done rvalid"}, {30'd0, m1_rvalid, m0_rvalid}, exp_bits);
        check({tag, " done rdata"},  rdata, v.exp_rd);
        check({tag, " done byteen"}, {28'd0, bus_byteen}, 32'd0);
        check({tag, " done raddr"},  bus_raddr, v.addr);
        check({tag, " done gnt"},    {30'd0, m1_gnt, m0_gnt}, 32'd0);
        @(negedge clk);
        check({tag, " idle rvalid"}, {30'd0, m1_rvalid, m0_rvalid}, 32'd0);
        check({tag, " idle raddr"},  bus_raddr, 32'd0);
        check({tag, " idle byteen"}, {28'd0, bus_byteen}, 32'd0);
    endtask

    initial begin
        int         ngnt;
        int         last_cyc;
        int         we_cnt;
        int         we_first;
        int         we_second;
        bit         seen;
        logic [1:0] exp_gnt[4];

        vt[0] = '{mst: 1'b0, addr: 32'h0000_0010, wdata: 32'h0,         be: 4'h0, brd: 32'hDEAD_BEEF, w: 0, exp_rd: 32'hDEAD_BEEF};
        vt[1] = '{mst: 1'b1, addr: 32'h0000_7F00, wdata: 32'h5,         be: 4'hF, brd: 32'h1234_5678, w: 0, exp_rd: 32'h0};
        vt[2] = '{mst: 1'b0, addr: 32'h0000_7F30, wdata: 32'h0,         be: 4'h0, brd: 32'hCAFE_0001, w: 2, exp_rd: 32'hCAFE_0001};
        vt[3] = '{mst: 1'b1, addr: 32'h0000_7F3F, wdata: 32'h0,         be: 4'h0, brd: 32'h0BAD_F00D, w: 2, exp_rd: 32'h0BAD_F00D};
        vt[4] = '{mst: 1'b0, addr: 32'h0000_7F2F, wdata: 32'h0,         be: 4'h0, brd: 32'h5555_AAAA, w: 0, exp_rd: 32'h5555_AAAA};
        vt[5] = '{mst: 1'b1, addr: 32'h0000_7F40, wdata: 32'hA5A5_0003, be: 4'h3, brd: 32'hFFFF_FFFF, w: 0, exp_rd: 32'h0};
        vt[6] = '{mst: 1'b0, addr: 32'h0000_7F34, wdata: 32'h0000_0041, be: 4'h1, brd: 32'h7777_7777, w: 2, exp_rd: 32'h0};

        m0_addr = '0; m0_wdata = '0; m0_byteen = '0;
        m1_addr = '0; m1_wdata = '0; m1_byteen = '0;
        bus_rdata = '0;
        m0_req = 1'b0; m1_req = 1'b0;
        sys_rstn = 1'b1;
        @(negedge clk);

        sys_rstn = 1'b0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        sys_rstn = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 7; i++) run_vec(i, vt[i]);

        // Arbitration order with both masters requesting continuously from reset.
        do_reset(2);
`ifdef BUS_ARB_FIXED_PRIO_EN
        exp_gnt = '{2'b01, 2'b01, 2'b01, 2'b01};
`else
        exp_gnt = '{2'b01, 2'b10, 2'b01, 2'b10};
`endif
        bus_rdata = 32'h0;
        drive_req(1'b0, 32'h0000_0010, 32'h0, 4'h0);
        drive_req(1'b1, 32'h0000_0020, 32'h0, 4'h0);
        ngnt = 0;
        last_cyc = -1;
        for (int c = 0; c < 40 && ngnt < 4; c++) begin
            @(negedge clk);
            if (m0_gnt || m1_gnt) begin
                check($sformatf("rr grant%0d", ngnt), {30'd0, m1_gnt, m0_gnt}, {30'd0, exp_gnt[ngnt]});
                if (last_cyc >= 0) check($sformatf("rr spacing%0d", ngnt), c - last_cyc, 3);
                last_cyc = c;
                ngnt++;
            end
        end
        check("rr grant count", ngnt, 4);
        drop_reqs();
        repeat (4) @(negedge clk);

        // Reset asserted while a slow read sits in WAIT, with M1 pending.
        bus_rdata = 32'h1111_2222;
        drive_req(1'b0, 32'h0000_7F30, 32'h0, 4'h0);
        @(posedge clk); @(negedge clk);
        check("rstwait gnt", {30'd0, m1_gnt, m0_gnt}, 32'd1);
        m0_req = 1'b0;
        drive_req(1'b1, 32'h0000_0044, 32'h0, 4'h0);
        @(negedge clk);
        check("rstwait in wait", {30'd0, m1_rvalid, m0_rvalid}, 32'd0);
        sys_rstn = 1'b0;
        @(negedge clk);
        check_all_zero("rstwait");
        sys_rstn = 1'b1;
        @(negedge clk);
        check("rstwait rearb gnt", {30'd0, m1_gnt, m0_gnt}, 32'd2);
        check("rstwait rearb raddr", bus_raddr, 32'h0000_0044);
        m1_req = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 10 && !seen; c++) begin
            @(negedge clk);
            if (m0_rvalid) check("rstwait stale m0 rvalid", 32'd1, 32'd0);
            if (m1_rvalid) seen = 1'b1;
        end
        check("rstwait m1 rvalid seen", {31'd0, seen}, 32'd1);
        @(negedge clk);

        // Back-to-back M0 writes: one strobe cycle each, three cycles apart.
        drive_req(1'b0, 32'h0000_0100, 32'h0000_00AA, 4'hF);
        we_cnt = 0; we_first = -1; we_second = -1; ngnt = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (m0_gnt) begin
                ngnt++;
                if (ngnt == 2) m0_req = 1'b0;
            end
            if (bus_byteen != 4'h0) begin
                if (we_cnt == 0) we_first = c;
                if (we_cnt == 1) we_second = c;
                we_cnt++;
            end
        end
        check("b2b we count", we_cnt, 2);
        check("b2b we spacing", we_second - we_first, 3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
